// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl: shares one SLICE-bit adder among up to four requesters.
// A W-bit add/subtract is run as a low pass then a high pass, with the
// inter-slice carry registered between them. Round-robin arbitration picks
// the next requester; only one transaction is in flight at a time.
module adder_share_ctrl #(
    parameter int N_REQ = 4,
    parameter int W     = 32,
    parameter int SLICE = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    input  logic [N_REQ-1:0]   req_sub,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [1:0]         rsp_id,
    output logic [W-1:0]       rsp_sum,
    output logic               rsp_cout,
    output logic               rsp_ovf,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // The one shared slice: SLICE-bit a + b + cin, carry-out in the top bit.
    function automatic logic [SLICE:0] slice_add(
        input logic [SLICE-1:0] a,
        input logic [SLICE-1:0] b,
        input logic             cin
    );
        return {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
    endfunction

    state_t             state_r;
    state_t             state_next_s;
    logic [1:0]         ptr_r;
    logic [1:0]         ptr_next_s;

    logic [3:0]         valid4_s;
    logic [3:0]         sub4_s;
    logic [W-1:0]       a_arr_s [4];
    logic [W-1:0]       b_arr_s [4];
    logic               grant_found_s;
    logic [1:0]         grant_idx_s;
    logic [1:0]         cand_idx_s;
    logic               hit_s;
    logic [N_REQ-1:0]   req_ready_s;

    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic               sub_r;
    logic [1:0]         id_r;
    logic [SLICE-1:0]   lo_sum_r;
    logic               c16_r;
    logic [SLICE:0]     lo_s;
    logic [SLICE:0]     hi_s;
    logic               c31_s;

    logic [W-1:0]       rsp_sum_r;
    logic               rsp_cout_r;
    logic               rsp_ovf_r;
    logic [1:0]         rsp_id_r;

    // Unpack the per-requester buses into arrays indexed by the grant.
    always_comb begin
        valid4_s = 4'(req_valid);
        sub4_s   = 4'(req_sub);
        for (int i = 0; i < 4; i++) begin
            a_arr_s[i] = {W{1'b0}};
            b_arr_s[i] = {W{1'b0}};
        end
        for (int i = 0; i < N_REQ; i++) begin
            a_arr_s[i] = req_a[i*W +: W];
            b_arr_s[i] = req_b[i*W +: W];
        end
    end

    // Round-robin search starting at ptr with wrap-around modulo N_REQ.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = 2'd0;
        cand_idx_s    = 2'd0;
        hit_s         = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_idx_s    = 2'((int'(ptr_r) + k) % N_REQ);
            hit_s         = !grant_found_s && valid4_s[cand_idx_s];
            grant_idx_s   = hit_s ? cand_idx_s : grant_idx_s;
            grant_found_s = grant_found_s || hit_s;
        end
        ptr_next_s = 2'((int'(grant_idx_s) + 1) % N_REQ);
    end

    // Next-state logic and the combinational grant handshake.
    always_comb begin
        state_next_s = state_r;
        req_ready_s  = {N_REQ{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (grant_found_s && rstn) begin
                    state_next_s = ST_LO;
                    req_ready_s  = N_REQ'(4'b0001 << grant_idx_s);
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LO:   state_next_s = ST_HI;
            ST_HI:   state_next_s = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register and round-robin pointer; ptr moves only on a grant.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            ptr_r   <= 2'd0;
        end else begin
            state_r <= state_next_s;
            if (state_r == ST_IDLE && grant_found_s) begin
                ptr_r <= ptr_next_s;
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    assign lo_s  = slice_add(a_r[SLICE-1:0], b_r[SLICE-1:0], sub_r);
    assign hi_s  = slice_add(a_r[W-1:SLICE], b_r[W-1:SLICE], c16_r);
    // Carry into the sign bit recovered from the sign-bit sum.
    assign c31_s = a_r[W-1] ^ b_r[W-1] ^ hi_s[SLICE-1];

    // Operand capture at grant, low pass, high pass, then hold the result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_r        <= {W{1'b0}};
            b_r        <= {W{1'b0}};
            sub_r      <= 1'b0;
            id_r       <= 2'd0;
            lo_sum_r   <= {SLICE{1'b0}};
            c16_r      <= 1'b0;
            rsp_sum_r  <= {W{1'b0}};
            rsp_cout_r <= 1'b0;
            rsp_ovf_r  <= 1'b0;
            rsp_id_r   <= 2'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_found_s) begin
                        a_r   <= a_arr_s[grant_idx_s];
                        b_r   <= sub4_s[grant_idx_s] ? ~b_arr_s[grant_idx_s]
                                                     : b_arr_s[grant_idx_s];
                        sub_r <= sub4_s[grant_idx_s];
                        id_r  <= grant_idx_s;
                    end else begin
                        a_r   <= a_r;
                    end
                end
                ST_LO: begin
                    lo_sum_r <= lo_s[SLICE-1:0];
                    c16_r    <= lo_s[SLICE];
                end
                ST_HI: begin
                    rsp_sum_r  <= {hi_s[SLICE-1:0], lo_sum_r};
                    rsp_cout_r <= hi_s[SLICE];
                    rsp_ovf_r  <= hi_s[SLICE] ^ c31_s;
                    rsp_id_r   <= id_r;
                end
                ST_RESP: begin
                    rsp_sum_r <= rsp_sum_r;
                end
                default: begin
                    rsp_sum_r <= rsp_sum_r;
                end
            endcase
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = (state_r == ST_RESP);
    assign busy      = (state_r != ST_IDLE);
    assign rsp_id    = rsp_id_r;
    assign rsp_sum   = rsp_sum_r;
    assign rsp_cout  = rsp_cout_r;
    assign rsp_ovf   = rsp_ovf_r;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Self-checking bench for adder_share_ctrl: directed vector table, reset and
// arbitration sequences, and randomized traffic against a transaction model.
module tb_adder_share_ctrl;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rstn;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_sub;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_sum;
    logic           rsp_cout;
    logic           rsp_ovf;
    logic           busy;

    logic [31:0]    la [4];
    logic [31:0]    lb [4];

    int tests = 0;
    int fails = 0;
    int model_ptr = 0;

    always #5 clk = ~clk;

    assign req_a = {la[3], la[2], la[1], la[0]};
    assign req_b = {lb[3], lb[2], lb[1], lb[0]};

    adder_share_ctrl #(.N_REQ(N), .W(W), .SLICE(16)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .busy(busy)
    );

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic sub);
        longint ua, ub, ur, sa, sb, sr;
        logic [31:0] s;
        logic co, ov;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            ur = ua - ub;
            sr = sa - sb;
            co = (ua >= ub);
        end else begin
            ur = ua + ub;
            sr = sa + sb;
            co = (ur > 64'sd4294967295);
        end
        s  = ur[31:0];
        ov = (sr != longint'($signed(s)));
        return {ov, co, s};
    endfunction

    function automatic int rr_pick(input logic [3:0] mask, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (mask[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'h0000_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic scramble();
        for (int i = 0; i < 4; i++) begin
            la[i] = $urandom;
            lb[i] = $urandom;
        end
        req_sub = 4'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 10 && busy; i++) tick();
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    // One isolated transaction from a single requester; starts and ends
    // just after a rising edge with the block idle.
    task automatic run_vec(input vec_t v);
        logic [3:0] onehot;
        onehot = 4'b0001 << v.id;
        scramble();
        la[v.id] = v.a;
        lb[v.id] = v.b;
        req_sub[v.id] = v.sub;
        req_valid = onehot;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("vec_ready", 64'(req_ready), 64'(onehot));
        chk("vec_busy_idle", 64'(busy), 64'd0);
        model_ptr = (v.id + 1) % 4;
        tick();
        req_valid = 4'b0000;
        scramble();
        @(negedge clk);
        chk("vec_lo_valid", 64'(rsp_valid), 64'd0);
        tick();
        @(negedge clk);
        chk("vec_hi_valid", 64'(rsp_valid), 64'd0);
        tick();
        @(negedge clk);
        chk("vec_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("vec_rsp_id", 64'(rsp_id), 64'(v.id));
        chk("vec_rsp_sum", 64'(rsp_sum), 64'(v.sum));
        chk("vec_rsp_cout", 64'(rsp_cout), 64'(v.cout));
        chk("vec_rsp_ovf", 64'(rsp_ovf), 64'(v.ovf));
        tick();
    endtask

    initial begin
        logic [33:0] exp_r;
        logic [31:0] hold_sum;
        int g;
        int last_grant_cyc;
        int n_grants;
        logic [3:0] mask;

        vecs[0] = '{0, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
        vecs[1] = '{1, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[2] = '{2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[3] = '{3, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[4] = '{0, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[5] = '{1, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[6] = '{2, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

        // Reset values
        rstn = 1'b0;
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        scramble();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_sum", 64'(rsp_sum), 64'd0);
        chk("rst_rsp_cout", 64'(rsp_cout), 64'd0);
        chk("rst_rsp_ovf", 64'(rsp_ovf), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rstn = 1'b1;
        tick();

        // Reset during LO with requester 2 in flight
        req_valid = 4'b0100;
        @(negedge clk);
        chk("rlo_grant2", 64'(req_ready), 64'b0100);
        tick();
        req_valid = 4'b0000;
        chk("rlo_busy_pre", 64'(busy), 64'd1);
        rstn = 1'b0;
        #1;
        chk("rlo_busy_async", 64'(busy), 64'd0);
        chk("rlo_valid_async", 64'(rsp_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rlo_valid_hold", 64'(rsp_valid), 64'd0);
        end
        rstn = 1'b1;
        model_ptr = 0;
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rlo_no_rsp", 64'(rsp_valid), 64'd0);
            tick();
        end

        // All four requesting, rsp_ready held high: fixed order, 4-cycle spacing
        scramble();
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        last_grant_cyc = -4;
        n_grants = 0;
        g = -1;
        for (int c = 0; c < 17; c++) begin
            @(negedge clk);
            if (req_ready != 4'b0000) begin
                int eg;
                eg = rr_pick(4'b1111, model_ptr);
                model_ptr = (eg + 1) % 4;
                chk("rr_onehot", 64'(req_ready), 64'(4'b0001 << eg));
                chk("rr_spacing", 64'(c - last_grant_cyc), 64'd4);
                last_grant_cyc = c;
                n_grants++;
                g = eg;
            end
            if (rsp_valid && g >= 0) begin
                exp_r = ref_add(la[g], lb[g], req_sub[g]);
                chk("rr_rsp_id", 64'(rsp_id), 64'(g));
                chk("rr_rsp_sum", 64'(rsp_sum), 64'(exp_r[31:0]));
            end
            tick();
        end
        chk("rr_grant_count", 64'(n_grants), 64'd5);
        req_valid = 4'b0000;
        wait_idle();

        // Directed vector table
        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: requester 3 granted, rsp_ready low for 10 cycles
        scramble();
        la[3] = 32'h1234_5678;
        lb[3] = 32'h0FED_CBA9;
        req_sub[3] = 1'b1;
        exp_r = ref_add(la[3], lb[3], 1'b1);
        req_valid = 4'b1000;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_grant3", 64'(req_ready), 64'b1000);
        model_ptr = 0;
        tick();
        req_valid = 4'b1111;
        scramble();
        tick();
        tick();
        @(negedge clk);
        chk("bp_valid", 64'(rsp_valid), 64'd1);
        chk("bp_sum", 64'(rsp_sum), 64'(exp_r[31:0]));
        chk("bp_cout", 64'(rsp_cout), 64'(exp_r[32]));
        chk("bp_ovf", 64'(rsp_ovf), 64'(exp_r[33]));
        hold_sum = rsp_sum;
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            chk("bp_hold_valid", 64'(rsp_valid), 64'd1);
            chk("bp_hold_ready", 64'(req_ready), 64'd0);
            chk("bp_hold_sum", 64'(rsp_sum), 64'(hold_sum));
            chk("bp_hold_id", 64'(rsp_id), 64'd3);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 64'(req_ready), 64'd0);
        tick();
        @(negedge clk);
        chk("bp_next_grant0", 64'(req_ready), 64'b0001);
        model_ptr = 1;
        tick();
        req_valid = 4'b0000;
        wait_idle();

        // Randomized traffic with random masks and random stalls
        for (int it = 0; it < 40; it++) begin
            int stall;
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) begin
                la[i] = pick_operand();
                lb[i] = pick_operand();
            end
            req_sub = 4'($urandom);
            req_valid = mask;
            rsp_ready = 1'b0;
            g = rr_pick(mask, model_ptr);
            exp_r = ref_add(la[g], lb[g], req_sub[g]);
            @(negedge clk);
            chk("rnd_grant", 64'(req_ready), 64'(4'b0001 << g));
            model_ptr = (g + 1) % 4;
            tick();
            scramble();
            req_valid = 4'($urandom);
            tick();
            tick();
            @(negedge clk);
            chk("rnd_valid", 64'(rsp_valid), 64'd1);
            chk("rnd_id", 64'(rsp_id), 64'(g));
            chk("rnd_sum", 64'(rsp_sum), 64'(exp_r[31:0]));
            chk("rnd_cout", 64'(rsp_cout), 64'(exp_r[32]));
            chk("rnd_ovf", 64'(rsp_ovf), 64'(exp_r[33]));
            stall = $urandom_range(0, 2);
            for (int s = 0; s < stall; s++) begin
                tick();
                @(negedge clk);
                chk("rnd_stall_sum", 64'(rsp_sum), 64'(exp_r[31:0]));
                chk("rnd_stall_ready", 64'(req_ready), 64'd0);
            end
            tick();
            rsp_ready = 1'b1;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adder_share_ctrl.md
# adder_share_ctrl

Sequencer and round-robin arbiter that shares one 16-bit adder slice among up to four requesters. Each request is a 32-bit add or subtract. The block runs the request as two 16-bit passes, low half then high half, and registers the inter-slice carry between them. It sits between the execute-stage requesters (ALU, address generation, branch compare) and the single shared adder resource, so the wide carry-lookahead logic is built only once.

## Interface
Parameters:
- N_REQ, 4: number of requesters, legal range 1..4.
- W, 32: operand width. Must equal 2*SLICE.
- SLICE, 16: adder slice width per pass.

Ports:
- clk, input, 1: single clock, rising edge.
- rstn, input, 1: asynchronous, active-low reset.
- req_valid, input, N_REQ: request valid, one bit per requester.
- req_ready, output, N_REQ: request accepted. One-hot or zero.
- req_a, input, N_REQ*W: operand A. Requester i occupies bits [i*W +: W].
- req_b, input, N_REQ*W: operand B, same packing as req_a.
- req_sub, input, N_REQ: 1 = A-B, 0 = A+B.
- rsp_valid, output, 1: result valid.
- rsp_ready, input, 1: consumer accepts the result.
- rsp_id, output, 2: index of the requester that owns the result.
- rsp_sum, output, W: result, modulo 2^W.
- rsp_cout, output, 1: carry out of bit W-1. For subtract, 1 means no borrow.
- rsp_ovf, output, 1: signed overflow.
- busy, output, 1: high in every state except IDLE.

## Operation
- Slice adder: 16-bit a + b + cin. The slice carry-out is bit 16 of the 17-bit sum, computed inside this block.
- Subtract: operand B is inverted and the initial carry-in is 1. Add: B passes unchanged and the initial carry-in is 0.
- FSM states and transitions:
  - IDLE: if any req_valid is set, grant one requester by round-robin. Assert req_ready[g] in that same cycle (combinationally). Latch A, B (already inverted for subtract), the sub flag and the id. Go to LO.
  - LO: add the low SLICE bits with the initial carry-in. Register the low sum and carry c16. Go to HI.
  - HI: add the high SLICE bits with cin = c16. Register the high sum, rsp_cout = bit 16 of this pass, and rsp_ovf = carry into bit 31 XOR carry out of bit 31. Go to RESP.
  - RESP: hold rsp_valid=1 and keep all rsp_* outputs stable. When rsp_ready=1, go to IDLE.
- Round-robin rule:
  - Search order starts at ptr and runs ptr, ptr+1, ... with wrap-around modulo N_REQ.
  - On a grant to g, ptr becomes (g+1) mod N_REQ.
  - ptr does not change in cycles with no grant.
- Only one transaction is in flight at a time. req_ready is 0 in every state except IDLE.
- Inputs are sampled only in the grant cycle. A requester may change req_a, req_b or req_sub after its handshake with no effect on the transaction.
- A requester that drops req_valid before being granted simply loses its turn. There is no error for this.
- Bits of req_valid at or above N_REQ are ignored.

## Timing
- Reset values:
  - state = IDLE, ptr = 0.
  - req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_sum = 0, rsp_cout = 0, rsp_ovf = 0, busy = 0.
- Latency: handshake in cycle T. rsp_valid rises at the edge ending cycle T+2, so it is high in cycle T+3.
- Throughput: with rsp_ready held at 1, one result every 4 cycles.
- RESP to IDLE: the cycle after the rsp handshake is IDLE. A new grant is possible in that cycle. There is no bypass grant in the RESP cycle itself.
- Backpressure: while rsp_ready=0, the block stays in RESP indefinitely with outputs frozen. Pending requests wait, and req_ready stays 0.
- Reset asserted mid-operation: the block returns to IDLE immediately and the in-flight transaction is discarded. No rsp_valid is produced for it.
- Simultaneous requests: exactly one bit of req_ready is high per grant. It is never asserted for a requester whose req_valid is 0.

## Test plan
- Reset during LO with requester 2 active, then release: rsp_valid stays 0. The next grant goes to requester 0 if all requesters are requesting (ptr was reset to 0).
- Single add from requester 0, A=0x0000FFFF, B=0x00000001: req_ready[0] high in the handshake cycle; rsp_valid high 3 cycles later; rsp_sum=0x00010000, rsp_cout=0, rsp_ovf=0, rsp_id=0. This exercises the inter-slice carry.
- Subtract from requester 1, A=0x80000000, B=0x00000001: rsp_sum=0x7FFFFFFF, rsp_cout=1, rsp_ovf=1, rsp_id=1.
- Add A=0xFFFFFFFF, B=0x00000001: rsp_sum=0x00000000, rsp_cout=1, rsp_ovf=0.
- All four requesters hold req_valid=1 with rsp_ready=1 throughout: grants come in order 0,1,2,3,0, with grant cycles spaced exactly 4 cycles apart.
- Requester 3 issues a request and rsp_ready is held at 0 for 10 cycles: rsp_* stay constant and req_ready stays 0 for all requesters. One cycle after rsp_ready=1, requester 0 is granted.
